// File: rtl/button_ce_ctrl.sv
// Button front end: per-button 2-flop sync, sampled saturating debounce and rising-edge pulse,
// plus a run/pause/step FSM that turns pulses p0/p1/p2 into the LED counter clock enable.
module button_ce_ctrl #(
   parameter int WIDTH          = 4,
   parameter int SAMPLE_CNT_MAX = 62500,
   parameter int PULSE_CNT_MAX  = 200,
   parameter int STEP_CYCLES    = 125000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] buttons,
   output logic [WIDTH-1:0] button_pulses,
   output logic             ce
);
   localparam int SW  = $clog2(SAMPLE_CNT_MAX);
   localparam int DW  = $clog2(PULSE_CNT_MAX + 1);
   localparam int STW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [SW-1:0]  SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
   localparam logic [DW-1:0]  PULSE_FULL  = DW'(PULSE_CNT_MAX);
   localparam logic [STW-1:0] STEP_LAST   = STW'(STEP_CYCLES - 1);

   typedef enum logic [1:0] {PAUSED, RUNNING, STEP} state_t;

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [SW-1:0]    sample_cnt_q, sample_cnt_d;
   logic             tick;
   logic [DW-1:0]    deb_cnt_q [WIDTH];
   logic [DW-1:0]    deb_cnt_d [WIDTH];
   logic [WIDTH-1:0] deb, deb_q;
   state_t           state_q, state_d;
   logic [STW-1:0]   step_cnt_q, step_cnt_d;
   logic             ce_q;
   logic             p0, p1, p2;

   assign tick         = (sample_cnt_q == SAMPLE_LAST);
   assign sample_cnt_d = tick ? '0 : sample_cnt_q + SW'(1);

   // Any low synchronized sample restarts qualification, independent of the tick phase.
   always_comb begin
      deb = '0;
      for (int i = 0; i < WIDTH; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (!sync2_q[i])
            deb_cnt_d[i] = '0;
         else if (tick && (deb_cnt_q[i] != PULSE_FULL))
            deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
         deb[i] = (deb_cnt_q[i] == PULSE_FULL);
      end
   end

   assign button_pulses = deb & ~deb_q;
   assign p0 = button_pulses[0];
   assign p1 = button_pulses[1];
   assign p2 = button_pulses[2];

   always_comb begin
      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      case (state_q)
         PAUSED: begin
            if (!p1) begin
               if (p0) begin
                  state_d = RUNNING;
               end else if (p2) begin
                  state_d    = STEP;
                  step_cnt_d = '0;
               end
            end
         end
         RUNNING: begin
            if (p1 || p0) state_d = PAUSED;
         end
         STEP: begin
            if (p1)                          state_d = PAUSED;
            else if (p0)                     state_d = RUNNING;
            else if (step_cnt_q == STEP_LAST) state_d = PAUSED;
            else                             step_cnt_d = step_cnt_q + STW'(1);
         end
         default: state_d = PAUSED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         sample_cnt_q <= '0;
         for (int i = 0; i < WIDTH; i++) deb_cnt_q[i] <= '0;
         deb_q        <= '0;
         state_q      <= PAUSED;
         step_cnt_q   <= '0;
         ce_q         <= 1'b0;
      end else begin
         sync1_q      <= buttons;
         sync2_q      <= sync1_q;
         sample_cnt_q <= sample_cnt_d;
         for (int i = 0; i < WIDTH; i++) deb_cnt_q[i] <= deb_cnt_d[i];
         deb_q        <= deb;
         state_q      <= state_d;
         step_cnt_q   <= step_cnt_d;
         // Registered from next state so ce follows the pulse by exactly one edge, glitch-free.
         ce_q         <= (state_d != PAUSED);
      end
   end

   assign ce = ce_q;

endmodule
